// File: rtl/dbus_decoder.sv
// rtl/dbus_decoder.sv - single-master data bus decoder with per-slave wait states
// Optional miss capture (ERR_ADDR/ERR_CNT) is built when DBUS_ERR_CAPTURE_EN is defined.
module dbus_decoder #(
  parameter int                 NSLV  = 2,
  parameter int                 RBITS = 12,
  parameter logic [NSLV*32-1:0] BASE  = {32'h7ff0_0000, 32'h0010_0000},
  parameter logic [NSLV*4-1:0]  WAIT  = {4'd2, 4'd0}
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                M_VALID,
  input  logic [29:0]         M_ADDR,
  input  logic [31:0]         M_WDATA,
  input  logic [3:0]          M_WSTB,
  output logic                M_READY,
  output logic [31:0]         M_RDATA,
  output logic                M_ERR,
`ifdef DBUS_ERR_CAPTURE_EN
  output logic [31:0]         ERR_ADDR,
  output logic [7:0]          ERR_CNT,
`endif
  output logic [NSLV-1:0]     S_CE,
  output logic [29:0]         S_ADDR,
  output logic [31:0]         S_WDATA,
  output logic [3:0]          S_WSTB,
  input  logic [NSLV*32-1:0]  S_RDATA
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] dec_idx, idx_q;
  logic          dec_hit, hit_q;
  logic [3:0]    dec_wait, cnt_q;
  logic [29:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstb_q;
  logic          accept;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_hit  = 1'b0;
    dec_idx  = '0;
    dec_wait = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (M_ADDR[29 -: RBITS] == BASE[32*i+31 -: RBITS]) begin
        dec_hit  = 1'b1;
        dec_idx  = IW'(i);
        dec_wait = WAIT[4*i +: 4];
      end
    end
  end

  assign accept = (state == ST_IDLE) && M_VALID && !RST;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = (dec_hit && dec_wait != 4'd0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt_q == 4'd0) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counter is loaded with WAIT-1 so RESP lands exactly WAIT cycles after the first WAIT cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstb_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q  <= M_ADDR;
        wdata_q <= M_WDATA;
        wstb_q  <= M_WSTB;
        idx_q   <= dec_idx;
        hit_q   <= dec_hit;
        cnt_q   <= (dec_hit && dec_wait != 4'd0) ? dec_wait - 4'd1 : 4'd0;
      end else if (state == ST_WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Strobes only pass through in the accept cycle, so each write hits the slave once.
  always_comb begin
    M_READY = 1'b0;
    M_ERR   = 1'b0;
    M_RDATA = '0;
    S_CE    = '0;
    S_WSTB  = '0;
    S_ADDR  = addr_q;
    S_WDATA = wdata_q;
    if (!RST) begin
      case (state)
        ST_IDLE: begin
          S_ADDR  = M_ADDR;
          S_WDATA = M_WDATA;
          if (accept && dec_hit) begin
            S_CE   = NSLV'(1) << dec_idx;
            S_WSTB = M_WSTB;
          end
        end
        ST_WAIT: begin
          if (hit_q) S_CE = NSLV'(1) << idx_q;
        end
        ST_RESP: begin
          if (hit_q) S_CE = NSLV'(1) << idx_q;
          M_READY = 1'b1;
          M_ERR   = !hit_q;
          if (hit_q && wstb_q == 4'd0) M_RDATA = S_RDATA[32*idx_q +: 32];
        end
        default: ;
      endcase
    end
  end

`ifdef DBUS_ERR_CAPTURE_EN
  // A zero count means no miss has been seen since reset, since the counter saturates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_ADDR <= '0;
      ERR_CNT  <= '0;
    end else if (accept && !dec_hit) begin
      if (ERR_CNT != 8'd255) ERR_CNT <= ERR_CNT + 8'd1;
      if (ERR_CNT == 8'd0) ERR_ADDR <= {M_ADDR, 2'b00};
    end
  end
`endif

endmodule

// File: tb/tb_dbus_decoder.sv
// tb/tb_dbus_decoder.sv - directed bench for dbus_decoder
// Checks decode, wait states, miss handling, reset abort and back-to-back reads.
module tb_dbus_decoder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        M_VALID;
  logic [29:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [3:0]  M_WSTB;
  logic [63:0] S_RDATA;

  logic        M_READY, M_ERR;
  logic [31:0] M_RDATA;
  logic [1:0]  S_CE;
  logic [29:0] S_ADDR;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTB;

  logic        o_ready, o_err;
  logic [31:0] o_rdata;
  logic [1:0]  o_ce;
  logic [29:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstb;
`ifdef DBUS_ERR_CAPTURE_EN
  logic [31:0] ERR_ADDR, o_err_addr;
  logic [7:0]  ERR_CNT, o_err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  dbus_decoder dut (
    .CLK(CLK), .RST(RST), .M_VALID(M_VALID), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_WSTB(M_WSTB), .M_READY(M_READY), .M_RDATA(M_RDATA), .M_ERR(M_ERR),
`ifdef DBUS_ERR_CAPTURE_EN
    .ERR_ADDR(ERR_ADDR), .ERR_CNT(ERR_CNT),
`endif
    .S_CE(S_CE), .S_ADDR(S_ADDR), .S_WDATA(S_WDATA), .S_WSTB(S_WSTB), .S_RDATA(S_RDATA)
  );

  // Regions 0 and 1 share the top 8 address bits.
  dbus_decoder #(
    .NSLV(2), .RBITS(8),
    .BASE({32'h0010_0000, 32'h0000_0000}),
    .WAIT({4'd0, 4'd0})
  ) dut_ovl (
    .CLK(CLK), .RST(RST), .M_VALID(M_VALID), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
    .M_WSTB(M_WSTB), .M_READY(o_ready), .M_RDATA(o_rdata), .M_ERR(o_err),
`ifdef DBUS_ERR_CAPTURE_EN
    .ERR_ADDR(o_err_addr), .ERR_CNT(o_err_cnt),
`endif
    .S_CE(o_ce), .S_ADDR(o_addr), .S_WDATA(o_wdata), .S_WSTB(o_wstb), .S_RDATA(S_RDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  logic [29:0] b2b_addr [3];
  logic [31:0] b2b_data [3];

  initial begin
    b2b_addr[0] = 30'h0004_0001; b2b_data[0] = 32'h1111_0000;
    b2b_addr[1] = 30'h0004_0002; b2b_data[1] = 32'h2222_0000;
    b2b_addr[2] = 30'h0004_0003; b2b_data[2] = 32'h3333_0000;

    // Reset with a valid request pending: nothing may leak out.
    RST = 1'b1; M_VALID = 1'b1; M_ADDR = 30'h0004_0010; M_WDATA = 32'h0; M_WSTB = 4'h0;
    S_RDATA = {32'hDEAD_BEEF, 32'h1234_5678};
    cyc; cyc;
    smp;
    chk("rst_ready", {31'd0, M_READY}, 32'd0);
    chk("rst_ce",    {30'd0, S_CE},    32'd0);
    chk("rst_wstb",  {28'd0, S_WSTB},  32'd0);
    chk("rst_rdata", M_RDATA,          32'd0);
    chk("rst_err",   {31'd0, M_ERR},   32'd0);

    // Read 0x0010_0040 from slave0, no wait states.
    cyc; RST = 1'b0;
    smp;
    chk("rd0_ce_A",   {30'd0, S_CE},   32'd1);
    chk("rd0_addr_A", {2'd0, S_ADDR},  32'h0004_0010);
    chk("rd0_rdy_A",  {31'd0, M_READY}, 32'd0);
    chk("ovl_ce",     {30'd0, o_ce},   32'd1);
    cyc; M_VALID = 1'b0; M_ADDR = 30'h3FFF_FFFF;
    smp;
    chk("rd0_ce_A1",   {30'd0, S_CE},    32'd1);
    chk("rd0_rdy_A1",  {31'd0, M_READY}, 32'd1);
    chk("rd0_data",    M_RDATA,          32'h1234_5678);
    chk("rd0_err",     {31'd0, M_ERR},   32'd0);
    chk("rd0_addr_A1", {2'd0, S_ADDR},   32'h0004_0010);
    cyc;
    smp;
    chk("rd0_rdy_A2", {31'd0, M_READY}, 32'd0);
    chk("rd0_ce_A2",  {30'd0, S_CE},    32'd0);

    // Write 0x7ff0_0008 to slave1, two wait states.
    cyc; M_VALID = 1'b1; M_ADDR = 30'h1FFC_0002; M_WSTB = 4'b1100; M_WDATA = 32'hAABB_CCDD;
    smp;
    chk("wr_ce_A",    {30'd0, S_CE},   32'd2);
    chk("wr_wstb_A",  {28'd0, S_WSTB}, 32'hC);
    chk("wr_wdata_A", S_WDATA,         32'hAABB_CCDD);
    cyc; M_VALID = 1'b0; M_WDATA = 32'h0; M_WSTB = 4'h0;
    smp;
    chk("wr_ce_A1",    {30'd0, S_CE},    32'd2);
    chk("wr_wstb_A1",  {28'd0, S_WSTB},  32'd0);
    chk("wr_rdy_A1",   {31'd0, M_READY}, 32'd0);
    chk("wr_wdata_A1", S_WDATA,          32'hAABB_CCDD);
    cyc;
    smp;
    chk("wr_rdy_A2", {31'd0, M_READY}, 32'd0);
    chk("wr_ce_A2",  {30'd0, S_CE},    32'd2);
    cyc;
    smp;
    chk("wr_rdy_A3",   {31'd0, M_READY}, 32'd1);
    chk("wr_rdata_A3", M_RDATA,          32'd0);
    chk("wr_err_A3",   {31'd0, M_ERR},   32'd0);
    chk("wr_ce_A3",    {30'd0, S_CE},    32'd2);
    chk("wr_wstb_A3",  {28'd0, S_WSTB},  32'd0);
    cyc;
    smp;
    chk("wr_rdy_A4", {31'd0, M_READY}, 32'd0);
    chk("wr_ce_A4",  {30'd0, S_CE},    32'd0);

    // Read 0x4000_0000: unmapped.
    cyc; M_VALID = 1'b1; M_ADDR = 30'h1000_0000;
    smp;
    chk("miss_ce_A", {30'd0, S_CE}, 32'd0);
    cyc; M_VALID = 1'b0;
    smp;
    chk("miss_rdy",   {31'd0, M_READY}, 32'd1);
    chk("miss_err",   {31'd0, M_ERR},   32'd1);
    chk("miss_rdata", M_RDATA,          32'd0);
    chk("miss_ce_A1", {30'd0, S_CE},    32'd0);
`ifdef DBUS_ERR_CAPTURE_EN
    chk("miss_eaddr", ERR_ADDR,         32'h4000_0000);
    chk("miss_ecnt",  {24'd0, ERR_CNT}, 32'd1);
`endif
    cyc;
    smp;
    chk("miss_rdy_A2", {31'd0, M_READY}, 32'd0);

    // Slave1 read aborted by reset in A+1.
    cyc; M_VALID = 1'b1; M_ADDR = 30'h1FFC_0004; M_WSTB = 4'h0;
    smp;
    chk("ab_ce_A", {30'd0, S_CE}, 32'd2);
    cyc; M_VALID = 1'b0; RST = 1'b1;
    smp;
    chk("ab_rdy_A1", {31'd0, M_READY}, 32'd0);
    cyc; RST = 1'b0;
    smp;
    chk("ab_ce_A2",  {30'd0, S_CE},    32'd0);
    chk("ab_rdy_A2", {31'd0, M_READY}, 32'd0);
`ifdef DBUS_ERR_CAPTURE_EN
    chk("ab_ecnt", {24'd0, ERR_CNT}, 32'd0);
`endif
    cyc;
    smp;
    chk("ab_rdy_A3", {31'd0, M_READY}, 32'd0);
    cyc;
    smp;
    chk("ab_rdy_A4", {31'd0, M_READY}, 32'd0);
    cyc; M_VALID = 1'b1; M_ADDR = 30'h0004_0020; S_RDATA[31:0] = 32'hCAFE_0001;
    smp;
    chk("ab_new_ce", {30'd0, S_CE}, 32'd1);
    cyc; M_VALID = 1'b0;
    smp;
    chk("ab_new_rdy",  {31'd0, M_READY}, 32'd1);
    chk("ab_new_data", M_RDATA,          32'hCAFE_0001);

    // M_VALID held high: one completion every second cycle.
    cyc; M_VALID = 1'b1; M_ADDR = b2b_addr[0]; S_RDATA[31:0] = b2b_data[0];
    for (int k = 0; k < 3; k++) begin
      smp;
      chk($sformatf("b2b%0d_rdy_A", k),  {31'd0, M_READY}, 32'd0);
      chk($sformatf("b2b%0d_addr_A", k), {2'd0, S_ADDR},   {2'd0, b2b_addr[k]});
      cyc;
      M_ADDR = (k < 2) ? b2b_addr[k+1] : 30'h0004_00FF;
      smp;
      chk($sformatf("b2b%0d_rdy_A1", k),  {31'd0, M_READY}, 32'd1);
      chk($sformatf("b2b%0d_data", k),    M_RDATA,          b2b_data[k]);
      chk($sformatf("b2b%0d_addr_A1", k), {2'd0, S_ADDR},   {2'd0, b2b_addr[k]});
      cyc;
      if (k < 2) S_RDATA[31:0] = b2b_data[k+1];
      else M_VALID = 1'b0;
    end
    smp;
    chk("b2b_idle_rdy", {31'd0, M_READY}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dbus_decoder.md
DBUS_DECODER -- requirements
Module: dbus_decoder

Interface
REQ-001 SHALL provide parameter NSLV, default 2: number of slave regions, 1..8.
REQ-002 SHALL provide parameter RBITS, default 12: number of upper address bits compared per region, 1..30.
REQ-003 SHALL provide parameter BASE (NSLV*32 bits), default {32'h7ff0_0000, 32'h0010_0000}: base of slave i in slice [32*i+31:32*i].
REQ-004 SHALL provide parameter WAIT (NSLV*4 bits), default {4'd2, 4'd0}: extra wait cycles for slave i.
REQ-005 CLK  in  1  single clock; all state changes on rising edge.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 M_VALID  in  1  master request; held until M_READY.
REQ-008 M_ADDR  in  30  word address [31:2].
REQ-009 M_WDATA  in  32  write data.
REQ-010 M_WSTB  in  4  byte write strobes; 0000 means read.
REQ-011 M_READY  out  1  one-cycle completion pulse.
REQ-012 M_RDATA  out  32  read data, valid when M_READY=1.
REQ-013 M_ERR  out  1  unmapped access, valid when M_READY=1.
REQ-014 S_CE  out  NSLV  one-hot slave chip enable.
REQ-015 S_ADDR / S_WDATA / S_WSTB  out  30 / 32 / 4  broadcast address, data and strobes.
REQ-016 S_RDATA  in  NSLV*32  per-slave read data; slave read latency is one cycle after CE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-018 Decode: slave i hits when M_ADDR[31:32-RBITS] == BASE_i[31:32-RBITS]; if several hit, lowest index wins.
REQ-019 Accept cycle A: IDLE and M_VALID=1. At edge A, latch addr/wdata/wstb/slave index/hit; load wait counter with WAIT_i.
REQ-020 In cycle A, S_CE[i], S_ADDR, S_WDATA and S_WSTB SHALL be driven combinationally from the master inputs.
REQ-021 After cycle A, S_CE[i] SHALL stay high through the RESP cycle, with S_WSTB forced to 0000 so each write is performed exactly once.
REQ-022 WAIT state: counter decrements each cycle; go to RESP when counter is 0. If WAIT_i=0, go straight from IDLE to RESP.
REQ-023 RESP cycle = A+1+WAIT_i: M_READY=1, M_RDATA = S_RDATA slice of the latched slave. State returns to IDLE at the next edge.
REQ-024 Miss (no hit): S_CE stays 0; RESP at A+1 with M_ERR=1, M_RDATA=0, no write performed.
REQ-025 M_RDATA SHALL be 0 whenever M_READY=0 or the access is a write.
REQ-026 No request is accepted in WAIT or RESP; back-to-back throughput is at most one access per 2 cycles.
REQ-027 Master inputs changing after A SHALL have no effect on the in-flight access.

Reset
REQ-028 RST=1 at an edge SHALL force IDLE, counter 0, latched index 0, and all outputs 0 (M_READY, M_ERR, M_RDATA, S_CE, S_WSTB).
REQ-029 Reset during WAIT or RESP SHALL abort with no M_READY pulse; the first acceptance is possible in the first cycle with RST=0.

Configuration
REQ-030 Macro DBUS_ERR_CAPTURE_EN defined: add outputs ERR_ADDR (32, {addr,2'b00} of first miss since reset) and ERR_CNT (8, saturating at 255 miss count), both reset to 0.
REQ-031 DBUS_ERR_CAPTURE_EN undefined: ERR_ADDR and ERR_CNT are absent; M_ERR is still produced.

Verification
REQ-032 Read 0x0010_0040 (slave0, WAIT 0), S_RDATA0=32'h1234_5678 -> S_CE=01 in A and A+1; M_READY at A+1, M_RDATA=32'h1234_5678, M_ERR=0.
REQ-033 Write 0x7ff0_0008, WSTB=1100, data 32'hAABB_CCDD -> S_CE=10; S_WSTB=1100 only in A; M_READY at A+3; M_RDATA=0.
REQ-034 Read 0x4000_0000 (unmapped) -> S_CE=00; M_READY at A+1 with M_ERR=1, M_RDATA=0; with macro, ERR_ADDR=32'h4000_0000, ERR_CNT=1.
REQ-035 RST asserted in cycle A+1 of a slave1 read -> no M_READY pulse, S_CE=00 next cycle; a new slave0 read completes normally.
REQ-036 M_VALID held high continuously over reads to slave0 -> M_READY every 2nd cycle; M_ADDR changed in cycle A+1 does not alter S_ADDR.
REQ-037 BASE with overlapping regions 0 and 1 -> lowest index wins: S_CE=01.
